// File: rtl/lc3b_types.sv
// Shared LC-3b processor types: opcodes, ROB tags, CDB broadcast word and
// reservation-station entry states.
package lc3b_types;

  localparam int unsigned DataWidth = 16;
  localparam int unsigned TagWidth  = 3;

  typedef logic [TagWidth-1:0]  lc3b_rob_addr;
  typedef logic [DataWidth-1:0] lc3b_word;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef struct packed {
    logic         valid;
    lc3b_rob_addr tag;
    lc3b_word     data;
  } CDB;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    WAIT = 2'd1,
    EXEC = 2'd2
  } rs_state_t;

endpackage

// File: rtl/rs_entry.sv
// One ALU reservation-station entry: issue-time field writes, CDB operand
// snooping and the FREE -> WAIT -> EXEC -> FREE lifecycle.
module rs_entry
  import lc3b_types::*;
#(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned TagWidth  = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sel_i,
  input  logic                 ld_busy_dest_i,
  input  logic                 ld_vj_i,
  input  logic                 ld_vk_i,
  input  logic                 ld_qj_i,
  input  logic                 ld_qk_i,
  input  logic                 ld_validj_i,
  input  logic                 ld_validk_i,
  input  lc3b_opcode           op_i,
  input  logic [DataWidth-1:0] vj_i,
  input  logic [DataWidth-1:0] vk_i,
  input  logic [TagWidth-1:0]  qj_i,
  input  logic [TagWidth-1:0]  qk_i,
  input  logic [TagWidth-1:0]  dest_i,
  input  logic                 validj_i,
  input  logic                 validk_i,
  input  logic                 cdb_valid_i,
  input  logic [TagWidth-1:0]  cdb_tag_i,
  input  logic [DataWidth-1:0] cdb_data_i,
  input  logic                 dispatch_i,
  input  logic                 complete_i,
  output logic                 busy_o,
  output logic                 ready_o,
  output lc3b_opcode           op_o,
  output logic [DataWidth-1:0] vj_o,
  output logic [DataWidth-1:0] vk_o,
  output logic [TagWidth-1:0]  dest_o
);

  rs_state_t            state_q, state_d;
  lc3b_opcode           op_q, op_d;
  logic [DataWidth-1:0] vj_q, vj_d, vk_q, vk_d;
  logic [TagWidth-1:0]  qj_q, qj_d, qk_q, qk_d, dest_q, dest_d;
  logic                 validj_q, validj_d, validk_q, validk_d;
  logic                 wr_en;

  // Writes to a non-FREE entry are protocol errors and are dropped.
  assign wr_en = sel_i && (state_q == FREE);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    vj_d     = vj_q;
    vk_d     = vk_q;
    qj_d     = qj_q;
    qk_d     = qk_q;
    validj_d = validj_q;
    validk_d = validk_q;
    dest_d   = dest_q;

    if (wr_en) begin
      if (ld_busy_dest_i) begin
        state_d = WAIT;
        op_d    = op_i;
        dest_d  = dest_i;
      end
      if (ld_vj_i)     vj_d     = vj_i;
      if (ld_vk_i)     vk_d     = vk_i;
      if (ld_qj_i)     qj_d     = qj_i;
      if (ld_qk_i)     qk_d     = qk_i;
      if (ld_validj_i) validj_d = validj_i;
      if (ld_validk_i) validk_d = validk_i;
    end

    // Snoop against post-issue fields so a same-cycle broadcast is not missed.
    if (state_d == WAIT && cdb_valid_i) begin
      if (!validj_d && cdb_tag_i == qj_d) begin
        vj_d     = cdb_data_i;
        validj_d = 1'b1;
      end
      if (!validk_d && cdb_tag_i == qk_d) begin
        vk_d     = cdb_data_i;
        validk_d = 1'b1;
      end
    end

    if (dispatch_i && state_q == WAIT) state_d = EXEC;
    if (complete_i && state_q == EXEC) state_d = FREE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= FREE;
      op_q     <= op_br;
      vj_q     <= '0;
      vk_q     <= '0;
      qj_q     <= '0;
      qk_q     <= '0;
      validj_q <= 1'b0;
      validk_q <= 1'b0;
      dest_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      vj_q     <= vj_d;
      vk_q     <= vk_d;
      qj_q     <= qj_d;
      qk_q     <= qk_d;
      validj_q <= validj_d;
      validk_q <= validk_d;
      dest_q   <= dest_d;
    end
  end

  assign busy_o  = (state_q != FREE);
  assign ready_o = (state_q == WAIT) && validj_q && validk_q;
  assign op_o    = op_q;
  assign vj_o    = vj_q;
  assign vk_o    = vk_q;
  assign dest_o  = dest_q;

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation-station bank: per-entry CDB snooping, lowest-index ready
// dispatch into an ADD/AND/NOT ALU, and a one-deep result register for the CDB.
module alu_reservation_station
  import lc3b_types::*;
#(
  parameter int unsigned data_width  = 16,
  parameter int unsigned tag_width   = 3,
  parameter int unsigned num_entries = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            res_station_id,
  input  lc3b_opcode            res_op_in,
  input  logic [data_width-1:0] res_Vj,
  input  logic [data_width-1:0] res_Vk,
  input  logic [tag_width-1:0]  res_Qj,
  input  logic [tag_width-1:0]  res_Qk,
  input  logic [tag_width-1:0]  res_dest,
  input  logic                  res_validJ,
  input  logic                  res_validK,
  input  logic                  issue_ld_busy_dest,
  input  logic                  issue_ld_Vj,
  input  logic                  issue_ld_Vk,
  input  logic                  issue_ld_Qj,
  input  logic                  issue_ld_Qk,
  input  logic                  issue_ld_validJ,
  input  logic                  issue_ld_validK,
  input  CDB                    CDB_in,
  input  logic                  cdb_grant,
  output logic                  alu_res1_busy,
  output logic                  alu_res2_busy,
  output logic                  alu_res3_busy,
  output logic                  cdb_req,
  output logic [tag_width-1:0]  cdb_tag,
  output logic [data_width-1:0] cdb_data
);

  logic [num_entries-1:0] busy, ready, sel_onehot, dispatch;
  lc3b_opcode             ent_op   [num_entries];
  logic [data_width-1:0]  ent_vj   [num_entries];
  logic [data_width-1:0]  ent_vk   [num_entries];
  logic [tag_width-1:0]   ent_dest [num_entries];

  logic                  req_q;
  logic [tag_width-1:0]  tag_q;
  logic [data_width-1:0] data_q;

  logic                  found, do_dispatch, complete;
  lc3b_opcode            sel_op;
  logic [data_width-1:0] sel_vj, sel_vk, alu_res;
  logic [tag_width-1:0]  sel_dest;

  assign complete    = req_q && cdb_grant;
  assign do_dispatch = found && (!req_q || cdb_grant);
  assign dispatch    = sel_onehot & {num_entries{do_dispatch}};

  for (genvar g = 0; g < num_entries; g++) begin : g_entry
    rs_entry #(
      .DataWidth(data_width),
      .TagWidth (tag_width)
    ) u_entry (
      .clk_i         (clk),
      .rst_i         (rst),
      .sel_i         (res_station_id == 3'(g)),
      .ld_busy_dest_i(issue_ld_busy_dest),
      .ld_vj_i       (issue_ld_Vj),
      .ld_vk_i       (issue_ld_Vk),
      .ld_qj_i       (issue_ld_Qj),
      .ld_qk_i       (issue_ld_Qk),
      .ld_validj_i   (issue_ld_validJ),
      .ld_validk_i   (issue_ld_validK),
      .op_i          (res_op_in),
      .vj_i          (res_Vj),
      .vk_i          (res_Vk),
      .qj_i          (res_Qj),
      .qk_i          (res_Qk),
      .dest_i        (res_dest),
      .validj_i      (res_validJ),
      .validk_i      (res_validK),
      .cdb_valid_i   (CDB_in.valid),
      .cdb_tag_i     (CDB_in.tag),
      .cdb_data_i    (CDB_in.data),
      .dispatch_i    (dispatch[g]),
      .complete_i    (complete),
      .busy_o        (busy[g]),
      .ready_o       (ready[g]),
      .op_o          (ent_op[g]),
      .vj_o          (ent_vj[g]),
      .vk_o          (ent_vk[g]),
      .dest_o        (ent_dest[g])
    );
  end

  // Lowest-index ready entry wins.
  always_comb begin
    found      = 1'b0;
    sel_onehot = '0;
    sel_op     = ent_op[0];
    sel_vj     = ent_vj[0];
    sel_vk     = ent_vk[0];
    sel_dest   = ent_dest[0];
    for (int i = 0; i < int'(num_entries); i++) begin
      if (ready[i] && !found) begin
        found         = 1'b1;
        sel_onehot[i] = 1'b1;
        sel_op        = ent_op[i];
        sel_vj        = ent_vj[i];
        sel_vk        = ent_vk[i];
        sel_dest      = ent_dest[i];
      end
    end
  end

  always_comb begin
    case (sel_op)
      op_add:  alu_res = sel_vj + sel_vk;
      op_and:  alu_res = sel_vj & sel_vk;
      op_not:  alu_res = ~sel_vj;
      default: alu_res = sel_vj;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q  <= 1'b0;
      tag_q  <= '0;
      data_q <= '0;
    end else if (do_dispatch) begin
      req_q  <= 1'b1;
      tag_q  <= sel_dest;
      data_q <= alu_res;
    end else if (complete) begin
      req_q  <= 1'b0;
    end
  end

  assign cdb_req       = req_q;
  assign cdb_tag       = tag_q;
  assign cdb_data      = data_q;
  assign alu_res1_busy = busy[0];
  assign alu_res2_busy = busy[1];
  assign alu_res3_busy = busy[2];

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: table-driven ALU vectors plus
// hand-written snoop, back-pressure and reset sequences.
module tb_alu_reservation_station;
  import lc3b_types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  res_station_id;
  lc3b_opcode  res_op_in;
  logic [15:0] res_Vj, res_Vk;
  logic [2:0]  res_Qj, res_Qk, res_dest;
  logic        res_validJ, res_validK;
  logic        issue_ld_busy_dest, issue_ld_Vj, issue_ld_Vk, issue_ld_Qj, issue_ld_Qk;
  logic        issue_ld_validJ, issue_ld_validK;
  CDB          CDB_in;
  logic        cdb_grant;
  logic        alu_res1_busy, alu_res2_busy, alu_res3_busy;
  logic        cdb_req;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_reservation_station dut (
    .clk               (clk),
    .rst               (rst),
    .res_station_id    (res_station_id),
    .res_op_in         (res_op_in),
    .res_Vj            (res_Vj),
    .res_Vk            (res_Vk),
    .res_Qj            (res_Qj),
    .res_Qk            (res_Qk),
    .res_dest          (res_dest),
    .res_validJ        (res_validJ),
    .res_validK        (res_validK),
    .issue_ld_busy_dest(issue_ld_busy_dest),
    .issue_ld_Vj       (issue_ld_Vj),
    .issue_ld_Vk       (issue_ld_Vk),
    .issue_ld_Qj       (issue_ld_Qj),
    .issue_ld_Qk       (issue_ld_Qk),
    .issue_ld_validJ   (issue_ld_validJ),
    .issue_ld_validK   (issue_ld_validK),
    .CDB_in            (CDB_in),
    .cdb_grant         (cdb_grant),
    .alu_res1_busy     (alu_res1_busy),
    .alu_res2_busy     (alu_res2_busy),
    .alu_res3_busy     (alu_res3_busy),
    .cdb_req           (cdb_req),
    .cdb_tag           (cdb_tag),
    .cdb_data          (cdb_data)
  );

  typedef struct {
    string       name;
    lc3b_opcode  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  dest;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    res_station_id     = 3'd0;
    res_op_in          = op_br;
    res_Vj             = '0;
    res_Vk             = '0;
    res_Qj             = '0;
    res_Qk             = '0;
    res_dest           = '0;
    res_validJ         = 1'b0;
    res_validK         = 1'b0;
    issue_ld_busy_dest = 1'b0;
    issue_ld_Vj        = 1'b0;
    issue_ld_Vk        = 1'b0;
    issue_ld_Qj        = 1'b0;
    issue_ld_Qk        = 1'b0;
    issue_ld_validJ    = 1'b0;
    issue_ld_validK    = 1'b0;
    CDB_in             = '0;
    cdb_grant          = 1'b0;
  endtask

  task automatic issue(input logic [2:0] id, input lc3b_opcode op, input logic [15:0] vj,
                       input logic [15:0] vk, input logic [2:0] qj, input logic [2:0] qk,
                       input logic vldj, input logic vldk, input logic [2:0] dest);
    res_station_id     = id;
    res_op_in          = op;
    res_Vj             = vj;
    res_Vk             = vk;
    res_Qj             = qj;
    res_Qk             = qk;
    res_validJ         = vldj;
    res_validK         = vldk;
    res_dest           = dest;
    issue_ld_busy_dest = 1'b1;
    issue_ld_Vj        = 1'b1;
    issue_ld_Vk        = 1'b1;
    issue_ld_Qj        = 1'b1;
    issue_ld_Qk        = 1'b1;
    issue_ld_validJ    = 1'b1;
    issue_ld_validK    = 1'b1;
  endtask

  initial begin
    vecs[0] = '{"add",      op_add, 16'h0003, 16'h0004, 3'd5, 16'h0007};
    vecs[1] = '{"add_wrap", op_add, 16'hFFFF, 16'h0001, 3'd1, 16'h0000};
    vecs[2] = '{"and",      op_and, 16'hAAAA, 16'h0FF0, 3'd2, 16'h0AA0};
    vecs[3] = '{"not",      op_not, 16'h00FF, 16'h1234, 3'd3, 16'hFF00};
    vecs[4] = '{"other_op", op_lea, 16'hBEEF, 16'h1111, 3'd7, 16'hBEEF};
    vecs[5] = '{"add_big",  op_add, 16'h8000, 16'h7FFF, 3'd6, 16'hFFFF};

    idle();
    rst = 1'b1;
    tick();
    tick();
    check("rst_req",   32'(cdb_req), 32'd0);
    check("rst_tag",   32'(cdb_tag), 32'd0);
    check("rst_data",  32'(cdb_data), 32'd0);
    check("rst_busy1", 32'(alu_res1_busy), 32'd0);
    check("rst_busy2", 32'(alu_res2_busy), 32'd0);
    check("rst_busy3", 32'(alu_res3_busy), 32'd0);
    rst = 1'b0;

    // Minimum-latency path through entry 0 for each ALU vector.
    for (int i = 0; i < 6; i++) begin
      issue(3'd0, vecs[i].op, vecs[i].a, vecs[i].b, 3'd0, 3'd0, 1'b1, 1'b1, vecs[i].dest);
      tick();
      idle();
      check({vecs[i].name, "_busy_up"}, 32'(alu_res1_busy), 32'd1);
      check({vecs[i].name, "_req_early"}, 32'(cdb_req), 32'd0);
      tick();
      check({vecs[i].name, "_req"}, 32'(cdb_req), 32'd1);
      check({vecs[i].name, "_tag"}, 32'(cdb_tag), 32'(vecs[i].dest));
      check({vecs[i].name, "_data"}, 32'(cdb_data), 32'(vecs[i].exp));
      cdb_grant = 1'b1;
      tick();
      cdb_grant = 1'b0;
      check({vecs[i].name, "_req_drop"}, 32'(cdb_req), 32'd0);
      check({vecs[i].name, "_busy_down"}, 32'(alu_res1_busy), 32'd0);
    end

    // AND on entry 1 waiting for tag 2 on the CDB.
    issue(3'd1, op_and, 16'h0000, 16'h00F0, 3'd2, 3'd0, 1'b0, 1'b1, 3'd3);
    tick();
    idle();
    check("snoop_busy2", 32'(alu_res2_busy), 32'd1);
    tick();
    tick();
    check("snoop_wait_req", 32'(cdb_req), 32'd0);
    CDB_in = '{valid: 1'b1, tag: 3'd2, data: 16'h0F3C};
    tick();
    CDB_in = '0;
    check("snoop_cap_req", 32'(cdb_req), 32'd0);
    tick();
    check("snoop_req", 32'(cdb_req), 32'd1);
    check("snoop_tag", 32'(cdb_tag), 32'd3);
    check("snoop_data", 32'(cdb_data), 32'h0030);
    cdb_grant = 1'b1;
    tick();
    cdb_grant = 1'b0;
    check("snoop_busy2_down", 32'(alu_res2_busy), 32'd0);

    // Operand broadcast in the same cycle as the issue word.
    issue(3'd2, op_add, 16'h0001, 16'h0000, 3'd0, 3'd4, 1'b1, 1'b0, 3'd6);
    CDB_in = '{valid: 1'b1, tag: 3'd4, data: 16'h1234};
    tick();
    idle();
    check("same_busy3", 32'(alu_res3_busy), 32'd1);
    check("same_req_early", 32'(cdb_req), 32'd0);
    tick();
    check("same_req", 32'(cdb_req), 32'd1);
    check("same_tag", 32'(cdb_tag), 32'd6);
    check("same_data", 32'(cdb_data), 32'h1235);
    cdb_grant = 1'b1;
    tick();
    cdb_grant = 1'b0;
    check("same_req_drop", 32'(cdb_req), 32'd0);

    // Back-pressure: entry 0 result held while entry 2 waits its turn.
    issue(3'd0, op_add, 16'h0010, 16'h0020, 3'd0, 3'd0, 1'b1, 1'b1, 3'd1);
    tick();
    issue(3'd2, op_and, 16'hFF00, 16'h0F0F, 3'd0, 3'd0, 1'b1, 1'b1, 3'd2);
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      check("hold_req", 32'(cdb_req), 32'd1);
      check("hold_tag", 32'(cdb_tag), 32'd1);
      check("hold_data", 32'(cdb_data), 32'h0030);
      check("hold_busy3", 32'(alu_res3_busy), 32'd1);
      // Write aimed at the busy entry 0 must be dropped.
      if (c == 1) issue(3'd0, op_add, 16'h1111, 16'h1111, 3'd0, 3'd0, 1'b1, 1'b1, 3'd7);
      tick();
      idle();
    end
    cdb_grant = 1'b1;
    tick();
    check("b2b_req", 32'(cdb_req), 32'd1);
    check("b2b_tag", 32'(cdb_tag), 32'd2);
    check("b2b_data", 32'(cdb_data), 32'h0F00);
    check("b2b_busy1", 32'(alu_res1_busy), 32'd0);
    check("b2b_busy3", 32'(alu_res3_busy), 32'd1);
    tick();
    cdb_grant = 1'b0;
    check("b2b_req_drop", 32'(cdb_req), 32'd0);
    check("b2b_busy3_down", 32'(alu_res3_busy), 32'd0);

    // Reset while an entry is in EXEC, with grant and issue in the same cycle.
    issue(3'd1, op_add, 16'h0005, 16'h0006, 3'd0, 3'd0, 1'b1, 1'b1, 3'd4);
    tick();
    idle();
    tick();
    check("pre_rst_req", 32'(cdb_req), 32'd1);
    check("pre_rst_data", 32'(cdb_data), 32'h000B);
    rst = 1'b1;
    issue(3'd2, op_add, 16'h0001, 16'h0001, 3'd0, 3'd0, 1'b1, 1'b1, 3'd5);
    cdb_grant = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    check("mid_rst_req", 32'(cdb_req), 32'd0);
    check("mid_rst_tag", 32'(cdb_tag), 32'd0);
    check("mid_rst_data", 32'(cdb_data), 32'd0);
    check("mid_rst_busy1", 32'(alu_res1_busy), 32'd0);
    check("mid_rst_busy2", 32'(alu_res2_busy), 32'd0);
    check("mid_rst_busy3", 32'(alu_res3_busy), 32'd0);
    tick();
    check("post_rst_req", 32'(cdb_req), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
